// File: rtl/wir_shift_stage.sv
// -----------------------------------------------------------------------------
// wir_shift_stage
//
// Shift/capture stage of an IEEE 1500 wrapper instruction register (WIR).
// Sits directly in front of the WIR update register. An instruction is loaded
// serially from WSI, and the current instruction can be captured in parallel
// for unload on WSO. Shifted bits are counted, and an update is passed to the
// downstream register only when exactly WIR_WIDTH bits were shifted since the
// last capture, update or reset. Any other update raises a sticky length
// error instead.
//
// Parameters:
//   WIR_WIDTH  instruction length in bits (>= 2)
//   CNT_W      shift-counter width (2**CNT_W - 1 > WIR_WIDTH)
//
// Ports:
//   WRCK        in   wrapper clock, all state changes on the rising edge
//   WRSTN       in   asynchronous active-low reset
//   SelectWIR   in   WIR selected; CaptureWR/ShiftWR/UpdateWR ignored when 0
//   CaptureWR   in   parallel capture request (highest priority)
//   ShiftWR     in   serial shift request
//   UpdateWR    in   update request (lowest priority)
//   WSI         in   serial data in (enters the MSB)
//   capture_in  in   current instruction from the update register
//   shift_data  out  shift register contents, to update register data_in
//   WSO         out  serial data out (LSB of the shift register)
//   update_en   out  qualified update strobe, combinational with UpdateWR
//   len_err     out  sticky shift-length error, cleared by capture or reset
//   bit_count   out  bits shifted since the last capture (saturating)
//
// Optional build macro:
//   WIR_WSO_NEGEDGE_EN  when defined, WSO is re-timed onto the falling edge
//                       of WRCK for half a cycle of hold margin downstream;
//                       otherwise WSO follows shift_data[0] directly.
// -----------------------------------------------------------------------------
module wir_shift_stage #(
   parameter int WIR_WIDTH = 3,
   parameter int CNT_W     = 4
) (
   input  logic                 WRCK,
   input  logic                 WRSTN,
   input  logic                 SelectWIR,
   input  logic                 CaptureWR,
   input  logic                 ShiftWR,
   input  logic                 UpdateWR,
   input  logic                 WSI,
   input  logic [WIR_WIDTH-1:0] capture_in,
   output logic [WIR_WIDTH-1:0] shift_data,
   output logic                 WSO,
   output logic                 update_en,
   output logic                 len_err,
   output logic [CNT_W-1:0]     bit_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURED = 2'd1,
      SHIFT    = 2'd2,
      OVER     = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_WIR = CNT_W'(WIR_WIDTH);

   state_t                 state_reg, state_next;
   logic [WIR_WIDTH-1:0]   shift_data_reg, shift_data_next;
   logic [WIR_WIDTH-1:0]   shifted;
   logic [CNT_W-1:0]       count_reg, count_next, count_inc;
   logic                   len_err_reg, len_err_next;
   logic                   do_capture, do_shift, do_update, good_update;

   // Only one request acts per cycle: capture beats shift beats update.
   assign do_capture = SelectWIR & CaptureWR;
   assign do_shift   = SelectWIR & ShiftWR & ~CaptureWR;
   assign do_update  = SelectWIR & UpdateWR & ~CaptureWR & ~ShiftWR;

   assign count_inc  = (count_reg == CNT_MAX) ? count_reg : count_reg + 1'b1;

   // An update is good only after exactly WIR_WIDTH shifts; CAPTURED, OVER
   // and IDLE (count 0) all fail this test.
   assign good_update = do_update & (state_reg == SHIFT) & (count_reg == CNT_WIR);

   // Right shift: WSI enters the MSB, each bit moves one place towards the LSB.
   assign shifted[WIR_WIDTH-1] = WSI;
   generate
      for (genvar gi = 0; gi < WIR_WIDTH - 1; gi++) begin : g_shift
         assign shifted[gi] = shift_data_reg[gi+1];
      end
   endgenerate

   // ---------------- FSM: state register ----------------
   always_ff @(posedge WRCK or negedge WRSTN) begin
      if (!WRSTN) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      if (do_capture) begin
         state_next = CAPTURED;
      end else if (do_shift) begin
         case (state_reg)
            IDLE, CAPTURED: state_next = SHIFT;
            SHIFT:          state_next = (count_inc > CNT_WIR) ? OVER : SHIFT;
            OVER:           state_next = OVER;
            default:        state_next = IDLE;
         endcase
      end else if (do_update) begin
         state_next = IDLE;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      update_en = good_update;
   end

   // ---------------- Datapath ----------------
   always_comb begin
      shift_data_next = shift_data_reg;
      count_next      = count_reg;
      len_err_next    = len_err_reg;
      if (do_capture) begin
         shift_data_next = capture_in;
         count_next      = '0;
         len_err_next    = 1'b0;
      end else if (do_shift) begin
         shift_data_next = shifted;
         count_next      = count_inc;
      end else if (do_update) begin
         // shift_data is held either way; the update register decides.
         count_next = '0;
         if (!good_update) begin
            len_err_next = 1'b1;
         end
      end
   end

   always_ff @(posedge WRCK or negedge WRSTN) begin
      if (!WRSTN) begin
         shift_data_reg <= '0;
         count_reg      <= '0;
         len_err_reg    <= 1'b0;
      end else begin
         shift_data_reg <= shift_data_next;
         count_reg      <= count_next;
         len_err_reg    <= len_err_next;
      end
   end

   assign shift_data = shift_data_reg;
   assign bit_count  = count_reg;
   assign len_err    = len_err_reg;

`ifdef WIR_WSO_NEGEDGE_EN
   logic wso_reg;

   // Falling-edge retime gives the next wrapper half a cycle of hold margin.
   always_ff @(negedge WRCK or negedge WRSTN) begin
      if (!WRSTN) begin
         wso_reg <= 1'b0;
      end else begin
         wso_reg <= shift_data_reg[0];
      end
   end

   assign WSO = wso_reg;
`else
   assign WSO = shift_data_reg[0];
`endif

endmodule

// File: tb/tb_wir_shift_stage.sv
// -----------------------------------------------------------------------------
// tb_wir_shift_stage
//
// Self-checking bench for wir_shift_stage. A reference model tracks the
// instruction bits, the number of shifts since the last capture/update/reset,
// and the sticky error; the state machine is not modelled, since an update is
// good exactly when that shift count equals WIR_WIDTH.
// -----------------------------------------------------------------------------
module tb_wir_shift_stage;

   localparam int W       = 3;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          WRCK = 1'b0;
   logic          WRSTN;
   logic          SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI;
   logic [W-1:0]  capture_in;
   logic [W-1:0]  shift_data;
   logic          WSO, update_en, len_err;
   logic [CW-1:0] bit_count;

   wir_shift_stage #(.WIR_WIDTH(W), .CNT_W(CW)) dut (
      .WRCK       (WRCK),
      .WRSTN      (WRSTN),
      .SelectWIR  (SelectWIR),
      .CaptureWR  (CaptureWR),
      .ShiftWR    (ShiftWR),
      .UpdateWR   (UpdateWR),
      .WSI        (WSI),
      .capture_in (capture_in),
      .shift_data (shift_data),
      .WSO        (WSO),
      .update_en  (update_en),
      .len_err    (len_err),
      .bit_count  (bit_count)
   );

   always #5 WRCK = ~WRCK;

   // Reference model
   logic [W-1:0] m_data;
   int           m_cnt;
   logic         m_lerr;

   int n_cmp = 0;
   int n_err = 0;

   // Values observed in the most recent run_cycle, for directed checks.
   logic last_uen, last_wso;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int sat_cnt(input int c);
      return (c > CNT_MAX) ? CNT_MAX : c;
   endfunction

   task automatic model_reset();
      m_data = '0;
      m_cnt  = 0;
      m_lerr = 1'b0;
   endtask

   task automatic model_step(input logic sel, input logic cap, input logic sh,
                             input logic upd, input logic wsi, input logic [W-1:0] cin);
      if (!sel) return;
      if (cap) begin
         m_data = cin;
         m_cnt  = 0;
         m_lerr = 1'b0;
      end else if (sh) begin
         m_data = {wsi, m_data[W-1:1]};
         m_cnt  = m_cnt + 1;
      end else if (upd) begin
         if (m_cnt != W) m_lerr = 1'b1;
         m_cnt = 0;
      end
   endtask

   // One transaction: drive on the falling edge, check just after, advance the
   // model on the rising edge and check WSO timing just after that.
   task automatic run_cycle(input logic sel, input logic cap, input logic sh,
                            input logic upd, input logic wsi, input logic [W-1:0] cin);
      logic exp_uen;
      logic old_lsb;
      @(negedge WRCK);
      SelectWIR  = sel;
      CaptureWR  = cap;
      ShiftWR    = sh;
      UpdateWR   = upd;
      WSI        = wsi;
      capture_in = cin;
      #1;
      exp_uen = sel & upd & ~cap & ~sh & (m_cnt == W);
      check("update_en",  {31'd0, update_en}, {31'd0, exp_uen});
      check("shift_data", {29'd0, shift_data}, {29'd0, m_data});
      check("bit_count",  {28'd0, bit_count}, sat_cnt(m_cnt));
      check("len_err",    {31'd0, len_err}, {31'd0, m_lerr});
      check("WSO",        {31'd0, WSO}, {31'd0, m_data[0]});
      last_uen = update_en;
      last_wso = WSO;
      $display("txn sel=%b cap=%b sh=%b upd=%b wsi=%b cin=%b | data=%b cnt=%0d uen=%b lerr=%b wso=%b",
               sel, cap, sh, upd, wsi, cin, shift_data, bit_count, update_en, len_err, WSO);
      old_lsb = m_data[0];
      @(posedge WRCK);
      model_step(sel, cap, sh, upd, wsi, cin);
      #1;
`ifdef WIR_WSO_NEGEDGE_EN
      check("WSO_hold_after_rise", {31'd0, WSO}, {31'd0, old_lsb});
`else
      check("WSO_after_rise", {31'd0, WSO}, {31'd0, m_data[0]});
`endif
   endtask

   task automatic idle_cycle();
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] rnd_cin;
      WRSTN = 1'b0;
      SelectWIR = 0; CaptureWR = 0; ShiftWR = 0; UpdateWR = 0; WSI = 0;
      capture_in = '0;
      model_reset();
      #2;
      check("rst_shift_data", {29'd0, shift_data}, 32'd0);
      check("rst_bit_count",  {28'd0, bit_count}, 32'd0);
      check("rst_len_err",    {31'd0, len_err}, 32'd0);
      check("rst_WSO",        {31'd0, WSO}, 32'd0);
      check("rst_update_en",  {31'd0, update_en}, 32'd0);
      @(negedge WRCK);
      #2 WRSTN = 1'b1;

      // Serial load 0,1,1 then a good update.
      run_cycle(1, 0, 1, 0, 0, '0);
      run_cycle(1, 0, 1, 0, 1, '0);
      run_cycle(1, 0, 1, 0, 1, '0);
      check("t1_data", {29'd0, shift_data}, 32'b110);
      check("t1_cnt",  {28'd0, bit_count}, 32'd3);
      run_cycle(1, 0, 0, 1, 0, '0);
      check("t1_uen_in_update", {31'd0, last_uen}, 32'd1);
      idle_cycle();
      check("t1_uen_after", {31'd0, last_uen}, 32'd0);
      check("t1_lerr", {31'd0, len_err}, 32'd0);

      // Capture 101 and unload it on WSO.
      run_cycle(1, 1, 0, 0, 0, 3'b101);
      run_cycle(1, 0, 1, 0, 0, '0);
      check("t2_wso0", {31'd0, last_wso}, 32'd1);
      run_cycle(1, 0, 1, 0, 0, '0);
      check("t2_wso1", {31'd0, last_wso}, 32'd0);
      run_cycle(1, 0, 1, 0, 0, '0);
      check("t2_wso2", {31'd0, last_wso}, 32'd1);
      check("t2_data", {29'd0, shift_data}, 32'd0);

      // Short shift: 2 bits then update.
      run_cycle(1, 1, 0, 0, 0, 3'b010);
      run_cycle(1, 0, 1, 0, 1, '0);
      run_cycle(1, 0, 1, 0, 0, '0);
      run_cycle(1, 0, 0, 1, 0, '0);
      check("t3_uen", {31'd0, last_uen}, 32'd0);
      check("t3_lerr_set", {31'd0, len_err}, 32'd1);
      run_cycle(1, 1, 0, 0, 0, 3'b111);
      check("t3_lerr_clr", {31'd0, len_err}, 32'd0);

      // Long shift: 4 bits then update.
      repeat (4) run_cycle(1, 0, 1, 0, 1, '0);
      check("t4_cnt", {28'd0, bit_count}, 32'd4);
      idle_cycle();
      check("t4_cnt_hold", {28'd0, bit_count}, 32'd4);
      run_cycle(1, 0, 0, 1, 0, '0);
      check("t4_uen", {31'd0, last_uen}, 32'd0);
      check("t4_lerr", {31'd0, len_err}, 32'd1);

      // Capture beats shift; deselected shift does nothing.
      run_cycle(1, 1, 1, 0, 1, 3'b011);
      check("t5_data", {29'd0, shift_data}, 32'b011);
      check("t5_cnt",  {28'd0, bit_count}, 32'd0);
      run_cycle(0, 0, 1, 0, 1, '0);
      check("t5_desel_data", {29'd0, shift_data}, 32'b011);
      check("t5_desel_cnt",  {28'd0, bit_count}, 32'd0);

      // Asynchronous reset after 2 of 3 shifts.
      run_cycle(1, 0, 1, 0, 1, '0);
      run_cycle(1, 0, 1, 0, 1, '0);
      SelectWIR = 0; ShiftWR = 0; CaptureWR = 0; UpdateWR = 0;
      #2 WRSTN = 1'b0;
      #1;
      model_reset();
      check("t6_data", {29'd0, shift_data}, 32'd0);
      check("t6_cnt",  {28'd0, bit_count}, 32'd0);
      check("t6_lerr", {31'd0, len_err}, 32'd0);
      check("t6_wso",  {31'd0, WSO}, 32'd0);
      @(negedge WRCK);
      #2 WRSTN = 1'b1;

      // Randomized traffic, with occasional well-formed frames.
      for (int i = 0; i < 300; i++) begin
         rnd_cin = W'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            run_cycle(1, 1, 0, 0, 0, rnd_cin);
            for (int k = 0; k < W; k++) run_cycle(1, 0, 1, 0, 1'($urandom), '0);
            run_cycle(1, 0, 0, 1, 0, '0);
         end else begin
            run_cycle(1'($urandom_range(0, 99) < 90),
                      1'($urandom_range(0, 99) < 10),
                      1'($urandom_range(0, 99) < 60),
                      1'($urandom_range(0, 99) < 25),
                      1'($urandom), rnd_cin);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
